mult_unit: RTL and testbench
============================

Name: mult_unit

Overview:
- Multi-cycle integer multiplier and HI/LO register file for the 5-stage MIPS pipeline.
- Responder to the decoder's mult/multu/mfhi/mflo control. It accepts a start pulse from the E stage and iterates a radix-2 shift-add.
- It raises busy so the hazard unit stalls dependent mfhi/mflo.
- It supplies HI or LO to the M-stage result mux when the aluormult select is set.

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH; iteration count = WIDTH.
- CNTW, 6, counter width; must satisfy 2^CNTW > WIDTH.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- multstartE  input  1  start request; single-cycle pulse from the E-stage control register (already zero when flushed).
- multsignE  input  1  1 = signed (mult), 0 = unsigned (multu); sampled with start.
- srcaE  input  WIDTH  multiplicand (rs value after forwarding).
- srcbE  input  WIDTH  multiplier (rt value after forwarding).
- lohiM  input  1  read select: 1 = HI, 0 = LO.
- hilordM  output  WIDTH  combinational read of HI or LO per lohiM.
- busy  output  1  high while an operation is in flight; hazard unit stalls mfhi/mflo in D.
- done  output  1  one-cycle pulse in the cycle after HI/LO are written.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE; HI=0, LO=0, busy=0, done=0; counter and internal operands cleared. This applies at any point, including mid-operation: the in-flight result is discarded and HI/LO are not partially written.
- State machine has three states: IDLE, CALC, FIX.
- IDLE:
  - busy=0.
  - On a rising edge with multstartE=1, latch operands:
    - If multsignE=1: store |srcaE| and |srcbE| as WIDTH-bit unsigned values (0x80000000 maps to 0x80000000), and store neg = srcaE[MSB] ^ srcbE[MSB].
    - If multsignE=0: store raw values with neg=0.
  - Clear the 2*WIDTH accumulator, set counter=0, go to CALC.
- CALC:
  - busy=1.
  - Each cycle: if multiplier LSB=1, add the multiplicand to the upper WIDTH+1 bits of the accumulator; then shift the {carry, accumulator} right by 1 and shift the multiplier right by 1; counter++.
  - After WIDTH iterations (counter == WIDTH-1 on that edge), go to FIX.
- FIX:
  - busy=1.
  - Write HI/LO = neg ? (two's-complement negation of the 2*WIDTH accumulator) : accumulator.
  - Go to IDLE; done=1 in the following cycle only.
- Latency:
  - Start sampled at edge T.
  - busy high for cycles T+1 .. T+WIDTH+1 (WIDTH+1 cycles).
  - New HI/LO visible on hilordM from cycle T+WIDTH+2, together with the done pulse.
- multstartE while busy: ignored, with no effect on the in-flight operation. The hazard unit must prevent this; the bench flags it as a protocol violation but the RTL tolerates it.
- multstartE in the same edge that FIX completes: ignored; the issuer must wait for busy=0.
- hilordM while busy: returns the previous HI/LO, never intermediate accumulator values.
- HI/LO change only in FIX and on reset.
- multsignE, srcaE and srcbE are don't-care except at the accepting edge.
- Arithmetic is exact for all operand pairs. The signed product of 0x80000000 and 0x80000000 is 2^62, which must not overflow.

Decomposition:
- Shared package: state encoding (IDLE=2'b00, CALC=2'b01, FIX=2'b10), WIDTH default, and the funct codes 6'b011000 mult, 6'b011001 multu, 6'b010000 mfhi, 6'b010010 mflo for bench cross-checking.
- One sub-module is natural: mult_shift_add, holding the accumulator, multiplier shift register and counter, controlled by load/step/finish strobes from the FSM in mult_unit.

Test Plan:
1. Unsigned max: multsignE=0, srcaE=0xFFFFFFFF, srcbE=0xFFFFFFFF -> busy high exactly 33 cycles; then HI=0xFFFFFFFE, LO=0x00000001; done pulses once.
2. Signed mixed: multsignE=1, srcaE=0xFFFFFFFD (-3), srcbE=0x00000007 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; the same operands with multsignE=0 give HI=0x00000006, LO=0xFFFFFFEB.
3. Signed corner cases:
   - 0x80000000 x 0x80000000 -> HI=0x40000000, LO=0x00000000.
   - 0x80000000 x 0x00000001 -> HI=0xFFFFFFFF, LO=0x80000000.
4. Read during busy: after 5x6 completes (LO=30), start 7x8; mid-operation, lohiM=0 -> hilordM=30; after done, hilordM=56 and lohiM=1 reads HI=0.
5. Start during busy: second multstartE with 2x2 issued 10 cycles into 3x4 -> ignored; LO=12 and exactly one done pulse.
6. Reset mid-operation: drive rst low 15 cycles into 0x1234x0x5678 -> HI=LO=0, busy=0 immediately. After release, 9x9 completes with LO=81 after 33 busy cycles.

Source files
------------

// File: rtl/mult_unit_pkg.sv
// Shared types and constants for the HI/LO multiplier.
// Imported by the unit, its datapath, its interface and the bench.
package mult_unit_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNTW_DEF  = 6;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } state_t;

  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;

endpackage

// File: rtl/mult_unit_if.sv
// E-stage start request and M-stage HI/LO read port.
// master = pipeline side, slave = mult_unit.
interface mult_unit_if
  import mult_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) ();

  logic             multstartE;
  logic             multsignE;
  logic [WIDTH-1:0] srcaE;
  logic [WIDTH-1:0] srcbE;
  logic             lohiM;
  logic [WIDTH-1:0] hilordM;
  logic             busy;
  logic             done;

  modport master (
    output multstartE,
    output multsignE,
    output srcaE,
    output srcbE,
    output lohiM,
    input  hilordM,
    input  busy,
    input  done
  );

  modport slave (
    input  multstartE,
    input  multsignE,
    input  srcaE,
    input  srcbE,
    input  lohiM,
    output hilordM,
    output busy,
    output done
  );

endinterface

// File: rtl/mult_shift_add.sv
// Radix-2 shift-add datapath on magnitudes; sign is
// reapplied to the full product on the way out.
module mult_shift_add
  import mult_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNTW  = CNTW_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic               finish,
  input  logic               sign,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               last,
  output logic [2*WIDTH-1:0] result
);

  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplr;
  logic [CNTW-1:0]    cnt;
  logic               neg;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     sum;

  // 0x80..0 negates to itself, which is its correct magnitude.
  always_comb begin
    a_mag = (sign && a[WIDTH-1]) ? (~a + 1'b1) : a;
    b_mag = (sign && b[WIDTH-1]) ? (~b + 1'b1) : b;
    sum   = {1'b0, acc[2*WIDTH-1:WIDTH]}
          + (mplr[0] ? {1'b0, mcand} : '0);
  end

  assign last   = (cnt == CNTW'(WIDTH-1));
  assign result = neg ? (~acc + 1'b1) : acc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc   <= '0;
      mcand <= '0;
      mplr  <= '0;
      cnt   <= '0;
      neg   <= 1'b0;
    end else if (load) begin
      acc   <= '0;
      mcand <= a_mag;
      mplr  <= b_mag;
      cnt   <= '0;
      neg   <= sign & (a[WIDTH-1] ^ b[WIDTH-1]);
    end else if (step) begin
      acc   <= {sum, acc[WIDTH-1:1]};
      mplr  <= mplr >> 1;
      cnt   <= cnt + CNTW'(1);
    end else if (finish) begin
      mcand <= '0;
      mplr  <= '0;
      cnt   <= '0;
      neg   <= 1'b0;
    end
  end

endmodule

// File: rtl/mult_unit.sv
// Multi-cycle mult/multu with HI/LO registers.
// HI/LO only move in FIX, so reads while busy see old values.
module mult_unit
  import mult_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNTW  = CNTW_DEF
) (
  input  logic        clk,
  input  logic        rst,
  mult_unit_if.slave  bus
);

  state_t             state;
  state_t             state_nxt;
  logic               load;
  logic               step;
  logic               finish;
  logic               last;
  logic [2*WIDTH-1:0] result;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic               done_q;

  mult_shift_add #(
    .WIDTH (WIDTH),
    .CNTW  (CNTW)
  ) u_dp (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .step   (step),
    .finish (finish),
    .sign   (bus.multsignE),
    .a      (bus.srcaE),
    .b      (bus.srcbE),
    .last   (last),
    .result (result)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.multstartE) begin
          load      = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        step = 1'b1;
        if (last) state_nxt = FIX;
      end
      FIX: begin
        finish    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi     <= '0;
      lo     <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= finish;
      if (finish) begin
        hi <= result[2*WIDTH-1:WIDTH];
        lo <= result[WIDTH-1:0];
      end
    end
  end

  assign bus.busy    = (state != IDLE);
  assign bus.done    = done_q;
  assign bus.hilordM = bus.lohiM ? hi : lo;

endmodule

// File: tb/tb_mult_unit.sv
// Directed bench for mult_unit with a cycle-level
// arithmetic model checked on every falling edge.
module tb_mult_unit;
  import mult_unit_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mult_unit_if #(.WIDTH(W)) bus ();

  mult_unit #(
    .WIDTH (W),
    .CNTW  (6)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] golden(input logic s,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    logic signed [63:0] sa, sb;
    if (s) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      return sa * sb;
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  logic [63:0] m_prod = '0;
  logic [63:0] m_pend = '0;
  int          m_cnt  = 0;
  logic        m_done = 1'b0;
  bit          live   = 1'b0;

  // Model: busy for W+1 cycles after accept, then result + done.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_prod = '0;
      m_cnt  = 0;
      m_done = 1'b0;
    end else begin
      live   = 1'b1;
      m_done = 1'b0;
      if (m_cnt > 0) begin
        if (bus.multstartE)
          $display("note: protocol violation, start while busy");
        m_cnt--;
        if (m_cnt == 0) begin
          m_prod = m_pend;
          m_done = 1'b1;
        end
      end else if (bus.multstartE) begin
        m_pend = golden(bus.multsignE, bus.srcaE, bus.srcbE);
        m_cnt  = W + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (live) begin
      chk("busy", 64'(bus.busy), 64'(m_cnt > 0));
      chk("done", 64'(bus.done), 64'(m_done));
      chk("hilordM", 64'(bus.hilordM),
          bus.lohiM ? 64'(m_prod[63:32]) : 64'(m_prod[31:0]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [5:0] f,
                       input logic [31:0] a,
                       input logic [31:0] b);
    bus.multstartE = 1'b1;
    bus.multsignE  = (f == FUNCT_MULT);
    bus.srcaE      = a;
    bus.srcbE      = b;
    tick();
    bus.multstartE = 1'b0;
    bus.multsignE  = 1'($urandom);
    bus.srcaE      = $urandom;
    bus.srcbE      = $urandom;
  endtask

  task automatic wait_done(output int nb, output int nd);
    bit seen = 1'b0;
    nb = 0;
    nd = 0;
    for (int i = 0; i < 80 && !seen; i++) begin
      if (bus.busy) nb++;
      if (bus.done) begin
        nd++;
        seen = 1'b1;
      end else begin
        tick();
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL timeout waiting for done");
    end
    repeat (3) begin
      tick();
      if (bus.done) nd++;
    end
  endtask

  task automatic read(input logic [5:0] f,
                      input logic [31:0] exp,
                      input string name);
    bus.lohiM = (f == FUNCT_MFHI);
    #1;
    chk(name, 64'(bus.hilordM), 64'(exp));
  endtask

  task automatic run(input logic [5:0] f,
                     input logic [31:0] a,
                     input logic [31:0] b,
                     input logic [31:0] hi,
                     input logic [31:0] lo,
                     input string name);
    int nb, nd;
    issue(f, a, b);
    wait_done(nb, nd);
    chk({name, " busy cycles"}, 64'(nb), 64'(33));
    chk({name, " done pulses"}, 64'(nd), 64'(1));
    read(FUNCT_MFHI, hi, {name, " HI"});
    read(FUNCT_MFLO, lo, {name, " LO"});
  endtask

  initial begin
    int nb, nd;
    bus.multstartE = 1'b0;
    bus.multsignE  = 1'b0;
    bus.srcaE      = '0;
    bus.srcbE      = '0;
    bus.lohiM      = 1'b0;
    repeat (2) tick();
    chk("reset busy", 64'(bus.busy), 64'(0));
    chk("reset done", 64'(bus.done), 64'(0));
    read(FUNCT_MFHI, 32'h0, "reset HI");
    read(FUNCT_MFLO, 32'h0, "reset LO");
    rst = 1'b1;
    tick();

    run(FUNCT_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
        32'hFFFF_FFFE, 32'h0000_0001, "umax");
    run(FUNCT_MULT, 32'hFFFF_FFFD, 32'h0000_0007,
        32'hFFFF_FFFF, 32'hFFFF_FFEB, "s -3x7");
    run(FUNCT_MULTU, 32'hFFFF_FFFD, 32'h0000_0007,
        32'h0000_0006, 32'hFFFF_FFEB, "u -3x7");
    run(FUNCT_MULT, 32'h8000_0000, 32'h8000_0000,
        32'h4000_0000, 32'h0000_0000, "s min*min");
    run(FUNCT_MULT, 32'h8000_0000, 32'h0000_0001,
        32'hFFFF_FFFF, 32'h8000_0000, "s min*1");
    run(FUNCT_MULT, 32'h0000_0005, 32'hFFFF_FFFA,
        32'hFFFF_FFFF, 32'hFFFF_FFE2, "s 5x-6");

    run(FUNCT_MULTU, 32'd5, 32'd6, 32'd0, 32'd30, "5x6");
    issue(FUNCT_MULTU, 32'd7, 32'd8);
    repeat (10) tick();
    read(FUNCT_MFLO, 32'd30, "LO while busy");
    read(FUNCT_MFHI, 32'd0, "HI while busy");
    wait_done(nb, nd);
    chk("7x8 done pulses", 64'(nd), 64'(1));
    read(FUNCT_MFLO, 32'd56, "7x8 LO");
    read(FUNCT_MFHI, 32'd0, "7x8 HI");

    issue(FUNCT_MULTU, 32'd3, 32'd4);
    repeat (9) tick();
    issue(FUNCT_MULTU, 32'd2, 32'd2);
    wait_done(nb, nd);
    chk("3x4 done pulses", 64'(nd), 64'(1));
    read(FUNCT_MFLO, 32'd12, "3x4 LO");
    read(FUNCT_MFHI, 32'd0, "3x4 HI");

    issue(FUNCT_MULTU, 32'h1234, 32'h5678);
    repeat (14) tick();
    rst = 1'b0;
    #1;
    chk("rst busy", 64'(bus.busy), 64'(0));
    chk("rst done", 64'(bus.done), 64'(0));
    read(FUNCT_MFHI, 32'h0, "rst HI");
    read(FUNCT_MFLO, 32'h0, "rst LO");
    tick();
    rst = 1'b1;
    tick();
    run(FUNCT_MULTU, 32'd9, 32'd9, 32'd0, 32'd81, "9x9");

    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
